// File: rtl/wb_pkg.sv
// Shared defaults and FSM encoding for the weight-buffer read sequencer.
package wb_pkg;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_LEN_W  = 13;
  localparam int DEF_REP_W  = 8;
  localparam int DEF_RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/wb_tag_dly.sv
// Fixed-depth shift line that carries word tags alongside the weight buffer read latency.
module wb_tag_dly #(
  parameter int DEPTH = 2,
  parameter int W     = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic [W-1:0] i_tag,
  output logic [W-1:0] o_tag
);
  logic [W-1:0] line_q [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign o_tag = line_q[DEPTH-1];
endmodule

// File: rtl/wb_rd_seq.sv
// Walks a (base, len) window of weight words for a number of passes, yielding the
// single SRAM port to the host or to PE stalls, with tags aligned to read data valid.
module wb_rd_seq
  import wb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int REP_W  = DEF_REP_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [REP_W-1:0]  i_repeat,
  input  logic              i_bypass,
  input  logic              i_stall,
  input  logic              i_host_en,
  output logic [ADDR_W-1:0] o_wb_raddr,
  output logic              o_wb_rd_en,
  output logic              o_bypass_wb,
  output logic              o_last,
  output logic              o_pass_last,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_state
);
  state_t            state_q;
  logic [ADDR_W-1:0] addr_q, base_q;
  logic [LEN_W-1:0]  len_q, word_cnt_q;
  logic [REP_W-1:0]  rep_q, pass_cnt_q;
  logic              byp_q, last_q, pass_q;
  logic [2:0]        drain_q;
  logic [1:0]        tag_out;

  logic issue, word_end, pass_end;
  assign issue    = (state_q == RUN) && !i_stall && !i_host_en;
  assign word_end = (word_cnt_q == len_q - LEN_W'(1));
  assign pass_end = (pass_cnt_q == rep_q - REP_W'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      rep_q       <= '0;
      word_cnt_q  <= '0;
      pass_cnt_q  <= '0;
      byp_q       <= 1'b0;
      drain_q     <= '0;
      o_wb_raddr  <= '0;
      o_wb_rd_en  <= 1'b0;
      o_bypass_wb <= 1'b0;
      last_q      <= 1'b0;
      pass_q      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_wb_rd_en  <= 1'b0;
      o_bypass_wb <= 1'b0;
      last_q      <= 1'b0;
      pass_q      <= 1'b0;
      o_done      <= 1'b0;
      if (i_abort) begin
        state_q <= IDLE;
        drain_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (i_start) begin
              // An empty window completes at once without touching the SRAM.
              if (i_len != '0 && i_repeat != '0) begin
                state_q    <= RUN;
                base_q     <= i_base_addr;
                addr_q     <= i_base_addr;
                len_q      <= i_len;
                rep_q      <= i_repeat;
                byp_q      <= i_bypass;
                word_cnt_q <= '0;
                pass_cnt_q <= '0;
              end else begin
                o_done <= 1'b1;
              end
            end
          end
          RUN: begin
            if (issue) begin
              o_wb_rd_en  <= 1'b1;
              o_wb_raddr  <= addr_q;
              o_bypass_wb <= byp_q;
              if (word_end) begin
                addr_q     <= base_q;
                word_cnt_q <= '0;
                pass_q     <= 1'b1;
                if (pass_end) begin
                  last_q  <= 1'b1;
                  state_q <= DRAIN;
                  drain_q <= '0;
                end else begin
                  pass_cnt_q <= pass_cnt_q + REP_W'(1);
                end
              end else begin
                addr_q     <= addr_q + ADDR_W'(1);
                word_cnt_q <= word_cnt_q + LEN_W'(1);
              end
            end
          end
          DRAIN: begin
            // Done lands one cycle after the final word's data-valid beat.
            if (drain_q == 3'(RD_LAT)) begin
              o_done  <= 1'b1;
              state_q <= IDLE;
            end else begin
              drain_q <= drain_q + 3'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  wb_tag_dly #(.DEPTH(RD_LAT), .W(2)) u_tag_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_abort),
    .i_tag ({o_wb_rd_en & last_q, o_wb_rd_en & pass_q}),
    .o_tag (tag_out)
  );

  assign o_last      = tag_out[1];
  assign o_pass_last = tag_out[0];
  assign o_busy      = (state_q != IDLE);
  assign o_state     = state_q;
endmodule

// File: tb/tb_wb_rd_seq.sv
// Directed bench for wb_rd_seq: address streams, tag and done timing, stalls, abort, reset.
module tb_wb_rd_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, bypass, stall, host_en;
  logic [12:0] base_addr, len;
  logic [7:0]  rep;
  logic [12:0] raddr;
  logic        rd_en, bypass_wb, last, pass_last, busy, done;
  logic [1:0]  state;

  wb_rd_seq #(.ADDR_W(13), .LEN_W(13), .REP_W(8), .RD_LAT(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_base_addr(base_addr), .i_len(len), .i_repeat(rep), .i_bypass(bypass),
    .i_stall(stall), .i_host_en(host_en), .o_wb_raddr(raddr), .o_wb_rd_en(rd_en),
    .o_bypass_wb(bypass_wb), .o_last(last), .o_pass_last(pass_last), .o_busy(busy),
    .o_done(done), .o_state(state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // event log sampled on the falling edge
  logic [12:0] got_addr[$];
  int rd_cyc[$], pl_cyc[$], last_cyc[$], done_cyc[$];
  int byp_beats, byp_bad;
  bit busy_hist [0:4095];

  always @(negedge clk) begin
    busy_hist[cyc[11:0]] = busy;
    if (rd_en) begin got_addr.push_back(raddr); rd_cyc.push_back(cyc); end
    if (pass_last) pl_cyc.push_back(cyc);
    if (last) last_cyc.push_back(cyc);
    if (done) done_cyc.push_back(cyc);
    if (bypass_wb && rd_en) byp_beats++;
    if (bypass_wb && !rd_en) byp_bad++;
  end

  // scoreboard
  logic [12:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_addrs(input string tag);
    check({tag, "_count"}, got_addr.size(), exp_q.size());
    foreach (exp_q[i]) check({tag, "_addr"}, got_addr[i], exp_q[i]);
    exp_q.delete();
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    got_addr.delete(); rd_cyc.delete(); pl_cyc.delete();
    last_cyc.delete(); done_cyc.delete();
    byp_beats = 0; byp_bad = 0;
  endtask

  task automatic launch(input logic [12:0] b, input logic [12:0] l, input logic [7:0] r,
                        input logic byp, output int s);
    clear_log();
    tick();
    base_addr = b; len = l; rep = r; bypass = byp; start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  int s;

  initial begin
    rst = 1'b1; start = 0; abort = 0; bypass = 0; stall = 0; host_en = 0;
    base_addr = '0; len = '0; rep = '0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", rd_en, 0);
    check("rst_raddr", raddr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tags", {last, pass_last, bypass_wb}, 0);
    check("rst_state", state, 0);
    tick();
    rst = 1'b0;
    idle(2);

    // two passes over 0x010..0x013, no stalls
    launch(13'h010, 13'd4, 8'd2, 1'b0, s);
    idle(16);
    exp_q = '{13'h010, 13'h011, 13'h012, 13'h013, 13'h010, 13'h011, 13'h012, 13'h013};
    check_addrs("t1");
    check("t1_first_rd", rd_cyc[0], s + 2);
    check("t1_final_rd", rd_cyc[7], s + 9);
    check("t1_pl_count", pl_cyc.size(), 2);
    check("t1_pl_beat4", pl_cyc[0], s + 7);
    check("t1_pl_beat8", pl_cyc[1], s + 11);
    check("t1_last_count", last_cyc.size(), 1);
    check("t1_last_beat8", last_cyc[0], s + 11);
    check("t1_done_count", done_cyc.size(), 1);
    check("t1_done_time", done_cyc[0], s + 12);
    check("t1_bypass_off", byp_beats + byp_bad, 0);

    // address wrap at the top of the buffer
    launch(13'h1FFE, 13'd4, 8'd1, 1'b0, s);
    idle(12);
    exp_q = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    check_addrs("t2");
    check("t2_done_count", done_cyc.size(), 1);
    check("t2_last_count", last_cyc.size(), 1);
    check("t2_last_time", last_cyc[0], s + 7);

    // stall on cycles s+2..s+4 and host access on s+6
    launch(13'h010, 13'd4, 8'd2, 1'b0, s);
    for (int k = 0; k < 22; k++) begin
      stall   = (cyc >= s + 2 && cyc <= s + 4);
      host_en = (cyc == s + 6);
      if (cyc == s + 3) check("t3_state_run", state, 2'd1);
      tick();
    end
    stall = 0; host_en = 0;
    exp_q = '{13'h010, 13'h011, 13'h012, 13'h013, 13'h010, 13'h011, 13'h012, 13'h013};
    check_addrs("t3");
    check("t3_rd1_after_stall", rd_cyc[1], s + 6);
    check("t3_rd2_after_host", rd_cyc[2], s + 8);
    check("t3_final_rd", rd_cyc[7], s + 13);
    check("t3_done_time", done_cyc[0], s + 16);
    begin
      int low = 0;
      for (int c = s + 1; c <= s + 15; c++) if (!busy_hist[c[11:0]]) low++;
      check("t3_busy_held", low, 0);
    end

    // empty windows
    launch(13'h050, 13'd0, 8'd3, 1'b0, s);
    idle(6);
    check("t4a_no_reads", rd_cyc.size(), 0);
    check("t4a_done_count", done_cyc.size(), 1);
    check("t4a_done_time", done_cyc[0], s + 1);
    check("t4a_not_busy", busy_hist[(s + 1) & 4095], 0);
    launch(13'h050, 13'd5, 8'd0, 1'b0, s);
    idle(6);
    check("t4b_no_reads", rd_cyc.size(), 0);
    check("t4b_done_count", done_cyc.size(), 1);
    check("t4b_done_time", done_cyc[0], s + 1);

    // abort after three words
    launch(13'h100, 13'd8, 8'd1, 1'b0, s);
    while (cyc < s + 4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    idle(10);
    check("t5_rd_count", rd_cyc.size(), 3);
    check("t5_busy_drop", busy_hist[(s + 5) & 4095], 0);
    check("t5_no_done", done_cyc.size(), 0);
    check("t5_no_last", last_cyc.size() + pl_cyc.size(), 0);

    // clean restart; a second start mid-run must be ignored
    launch(13'h020, 13'd3, 8'd1, 1'b0, s);
    while (cyc < s + 2) tick();
    start = 1'b1; base_addr = 13'h300; len = 13'd1;
    tick();
    start = 1'b0;
    idle(10);
    exp_q = '{13'h020, 13'h021, 13'h022};
    check_addrs("t6");
    check("t6_done_count", done_cyc.size(), 1);
    check("t6_done_time", done_cyc[0], s + 7);
    check("t6_last_time", last_cyc[0], s + 6);

    // bypass travels only with read beats
    launch(13'h005, 13'd2, 8'd1, 1'b1, s);
    idle(8);
    bypass = 1'b0;
    check("t7_rd_count", rd_cyc.size(), 2);
    check("t7_bypass_beats", byp_beats, 2);
    check("t7_bypass_stray", byp_bad, 0);

    // asynchronous reset mid-run
    launch(13'h040, 13'd8, 8'd1, 1'b0, s);
    while (cyc < s + 4) tick();
    check("t8_rd_before_rst", rd_en, 1);
    rst = 1'b1;
    #1;
    check("t8_rst_rd_en", rd_en, 0);
    check("t8_rst_raddr", raddr, 0);
    check("t8_rst_busy", busy, 0);
    check("t8_rst_state", state, 0);
    tick();
    rst = 1'b0;
    clear_log();
    idle(12);
    check("t8_no_reads_after", rd_cyc.size(), 0);
    check("t8_no_done", done_cyc.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
